mem_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single memory bus port between the instruction-fetch requester and the data requester of the CPU core. It grants one transaction at a time on the stb/ack memory bus and routes the slave's data and ack back to the granted master. Data accesses have priority, bounded by an instruction-starvation limit, and a watchdog aborts transactions the slave never acknowledges. It sits between the CPU core's bus sub-interfaces and the memory bus slave.

---
 rtl/biu_pkg.sv | 23 ++
 rtl/bus_watchdog.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 111 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package biu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IM_XFER = 2'b01,
        DM_XFER = 2'b10
    } state_t;

    localparam logic [1:0] GNT_NONE    = 2'b00;
    localparam logic [1:0] GNT_IM      = 2'b01;
    localparam logic [1:0] GNT_DM      = 2'b10;
    localparam logic [3:0] BYTESEL_ALL = 4'b1111;

    // Request fields latched onto the bus at grant time.
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } bus_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog: flags a timeout when a transfer goes TIMEOUT_CYCLES
// cycles without ack. TIMEOUT_CYCLES = 0 disables it.
module bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic run,
    input  logic ack,
    output logic timeout
);

    localparam logic       EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [9:0] LAST = EN ? 10'(TIMEOUT_CYCLES - 1) : 10'd0;

    logic [9:0] wd_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            wd_cnt <= '0;
        else if (clear)
            wd_cnt <= '0;
        else if (run && !ack)
            wd_cnt <= wd_cnt + 10'd1;
    end

    // Ack in the same cycle wins over the timeout.
    assign timeout = EN && run && !ack && (wd_cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction / data) arbiter for a single stb/ack memory bus.
// Data has priority, bounded by a starvation limit for waiting instruction fetches.
module mem_bus_arbiter
    import biu_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        im_stb_i,
    input  logic [31:0] im_adr_i,
    output logic [31:0] im_dat_o,
    output logic        im_ack_o,
    output logic        im_err_o,
    input  logic        dm_stb_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_adr_i,
    input  logic [31:0] dm_dat_i,
    input  logic [3:0]  dm_sel_i,
    output logic [31:0] dm_dat_o,
    output logic        dm_ack_o,
    output logic        dm_err_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [31:0] bus_dat_o,
    output logic [3:0]  bus_sel_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    output logic [1:0]  grant_o
);

    state_t     state;
    bus_req_t   req;
    logic [3:0] starve_cnt;
    logic       dm_win;
    logic       grant;
    logic       timeout;

    assign dm_win = dm_stb_i && (!im_stb_i || (starve_cnt < 4'(STARVE_LIMIT)));
    assign grant  = (state == IDLE) && (dm_stb_i || im_stb_i);

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (grant),
        .run    (state != IDLE),
        .ack    (bus_ack_i),
        .timeout(timeout)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            grant_o    <= GNT_NONE;
            bus_stb_o  <= 1'b0;
            req        <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_win) begin
                        state     <= DM_XFER;
                        grant_o   <= GNT_DM;
                        bus_stb_o <= 1'b1;
                        req       <= '{we: dm_we_i, adr: dm_adr_i, dat: dm_dat_i, sel: dm_sel_i};
                        if (im_stb_i && starve_cnt != 4'hF)
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (im_stb_i) begin
                        state      <= IM_XFER;
                        grant_o    <= GNT_IM;
                        bus_stb_o  <= 1'b1;
                        req        <= '{we: 1'b0, adr: im_adr_i, dat: 32'd0, sel: BYTESEL_ALL};
                        starve_cnt <= '0;
                    end
                end
                IM_XFER, DM_XFER: begin
                    // Timeout leaves starve_cnt alone so a stuck data slave
                    // cannot reset the instruction side's fairness credit.
                    if (bus_ack_i || timeout) begin
                        state     <= IDLE;
                        grant_o   <= GNT_NONE;
                        bus_stb_o <= 1'b0;
                        req       <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant_o   <= GNT_NONE;
                    bus_stb_o <= 1'b0;
                end
            endcase
        end
    end

    assign bus_we_o  = req.we;
    assign bus_adr_o = req.adr;
    assign bus_dat_o = req.dat;
    assign bus_sel_o = req.sel;

    assign im_ack_o = (state == IM_XFER) && bus_ack_i;
    assign dm_ack_o = (state == DM_XFER) && bus_ack_i;
    assign im_err_o = (state == IM_XFER) && timeout;
    assign dm_err_o = (state == DM_XFER) && timeout;
    assign im_dat_o = im_ack_o ? bus_dat_i : 32'd0;
    assign dm_dat_o = dm_ack_o ? bus_dat_i : 32'd0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with STARVE_LIMIT=4, TIMEOUT_CYCLES=8.
module tb_mem_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        im_stb_i;
    logic [31:0] im_adr_i;
    logic [31:0] im_dat_o;
    logic        im_ack_o;
    logic        im_err_o;
    logic        dm_stb_i;
    logic        dm_we_i;
    logic [31:0] dm_adr_i;
    logic [31:0] dm_dat_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_dat_o;
    logic        dm_ack_o;
    logic        dm_err_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [31:0] bus_adr_o;
    logic [31:0] bus_dat_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;
    logic [1:0]  grant_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk_i = ~clk_i;

    mem_bus_arbiter #(
        .STARVE_LIMIT  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .im_stb_i (im_stb_i),
        .im_adr_i (im_adr_i),
        .im_dat_o (im_dat_o),
        .im_ack_o (im_ack_o),
        .im_err_o (im_err_o),
        .dm_stb_i (dm_stb_i),
        .dm_we_i  (dm_we_i),
        .dm_adr_i (dm_adr_i),
        .dm_dat_i (dm_dat_i),
        .dm_sel_i (dm_sel_i),
        .dm_dat_o (dm_dat_o),
        .dm_ack_o (dm_ack_o),
        .dm_err_o (dm_err_o),
        .bus_stb_o(bus_stb_o),
        .bus_we_o (bus_we_o),
        .bus_adr_o(bus_adr_o),
        .bus_dat_o(bus_dat_o),
        .bus_sel_o(bus_sel_o),
        .bus_dat_i(bus_dat_i),
        .bus_ack_i(bus_ack_i),
        .grant_o  (grant_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    logic [1:0] exp_g [12] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};

    initial begin
        rst_i = 1'b0;
        im_stb_i = 0; im_adr_i = 0;
        dm_stb_i = 0; dm_we_i = 0; dm_adr_i = 0; dm_dat_i = 0; dm_sel_i = 0;
        bus_dat_i = 0; bus_ack_i = 0;
        #2;
        chk("rst_stb", 32'(bus_stb_o), 0);
        chk("rst_gnt", 32'(grant_o), 0);
        chk("rst_adr", bus_adr_o, 0);
        chk("rst_acks", 32'({im_ack_o, dm_ack_o, im_err_o, dm_err_o}), 0);
        smp(); rst_i = 1'b1;
        nxt(); nxt();

        // single instruction read
        im_stb_i = 1; im_adr_i = 32'h0000_0040;
        nxt(); smp();
        chk("t1_gnt", 32'(grant_o), 1);
        chk("t1_stb", 32'(bus_stb_o), 1);
        chk("t1_adr", bus_adr_o, 32'h40);
        chk("t1_sel", 32'(bus_sel_o), 32'hF);
        chk("t1_we", 32'(bus_we_o), 0);
        chk("t1_dat", bus_dat_o, 0);
        chk("t1_noack", 32'(im_ack_o), 0);
        nxt(); bus_ack_i = 1; bus_dat_i = 32'hCAFE_0001;
        smp();
        chk("t1_ack", 32'(im_ack_o), 1);
        chk("t1_rdat", im_dat_o, 32'hCAFE_0001);
        chk("t1_dm_ack", 32'(dm_ack_o), 0);
        chk("t1_dm_dat", dm_dat_o, 0);
        nxt(); im_stb_i = 0; bus_ack_i = 0; bus_dat_i = 0;
        smp();
        chk("t1_gnt_idle", 32'(grant_o), 0);
        chk("t1_stb_idle", 32'(bus_stb_o), 0);

        // simultaneous requests: data first, instruction after one idle
        nxt();
        im_stb_i = 1; im_adr_i = 32'h80;
        dm_stb_i = 1; dm_we_i = 1; dm_adr_i = 32'h100; dm_dat_i = 32'hDEAD_BEEF; dm_sel_i = 4'b0011;
        nxt(); smp();
        chk("t2_gnt_dm", 32'(grant_o), 2);
        chk("t2_wdat", bus_dat_o, 32'hDEAD_BEEF);
        chk("t2_sel", 32'(bus_sel_o), 32'h3);
        chk("t2_we", 32'(bus_we_o), 1);
        chk("t2_adr", bus_adr_o, 32'h100);
        nxt(); bus_ack_i = 1; bus_dat_i = 32'h55; dm_dat_i = 32'h1234_5678; dm_sel_i = 4'hF;
        smp();
        chk("t2_latched_dat", bus_dat_o, 32'hDEAD_BEEF);
        chk("t2_latched_sel", 32'(bus_sel_o), 32'h3);
        chk("t2_dm_ack", 32'(dm_ack_o), 1);
        chk("t2_dm_dat", dm_dat_o, 32'h55);
        chk("t2_im_ack", 32'(im_ack_o), 0);
        chk("t2_im_dat", im_dat_o, 0);
        nxt(); dm_stb_i = 0; bus_ack_i = 0; bus_dat_i = 0;
        smp();
        chk("t2_gap", 32'(grant_o), 0);
        nxt(); smp();
        chk("t2_gnt_im", 32'(grant_o), 1);
        chk("t2_im_adr", bus_adr_o, 32'h80);
        chk("t2_im_sel", 32'(bus_sel_o), 32'hF);
        nxt(); bus_ack_i = 1;
        smp();
        chk("t2_im_ack2", 32'(im_ack_o), 1);
        nxt(); im_stb_i = 0; bus_ack_i = 0; dm_we_i = 0;
        nxt();

        // starvation limit: four data grants, then instruction
        im_stb_i = 1; dm_stb_i = 1; bus_ack_i = 1; bus_dat_i = 32'hA5A5;
        for (int i = 0; i < 12; i++) begin
            smp();
            chk($sformatf("t3_gnt%0d", i), 32'(grant_o), 32'(exp_g[i]));
            if (i == 7) chk("t3_starve4", 32'(dut.starve_cnt), 4);
            if (i == 9) chk("t3_starve0", 32'(dut.starve_cnt), 0);
            nxt();
        end
        im_stb_i = 0; dm_stb_i = 0; bus_ack_i = 0; bus_dat_i = 0;
        nxt();

        // data timeout
        dm_stb_i = 1; dm_adr_i = 32'h200;
        for (int c = 1; c <= 8; c++) begin
            nxt(); smp();
            chk($sformatf("t4_err%0d", c), 32'(dm_err_o), 32'(c == 8));
            chk($sformatf("t4_ack%0d", c), 32'(dm_ack_o), 0);
        end
        chk("t4_stb_last", 32'(bus_stb_o), 1);
        nxt(); dm_stb_i = 0;
        smp();
        chk("t4_stb_after", 32'(bus_stb_o), 0);
        chk("t4_gnt_after", 32'(grant_o), 0);
        chk("t4_starve_kept", 32'(dut.starve_cnt), 1);

        // ack in the timeout cycle wins
        nxt(); dm_stb_i = 1;
        for (int c = 1; c <= 8; c++) begin
            nxt();
            if (c == 8) bus_ack_i = 1;
            smp();
        end
        chk("t5_ack", 32'(dm_ack_o), 1);
        chk("t5_err", 32'(dm_err_o), 0);
        nxt(); dm_stb_i = 0; bus_ack_i = 0;
        smp();
        chk("t5_gnt_after", 32'(grant_o), 0);

        // instruction timeout
        nxt(); im_stb_i = 1; im_adr_i = 32'h300;
        for (int c = 1; c <= 8; c++) begin
            nxt(); smp();
            chk($sformatf("t5i_err%0d", c), 32'(im_err_o), 32'(c == 8));
            chk($sformatf("t5i_dmerr%0d", c), 32'(dm_err_o), 0);
        end
        nxt(); im_stb_i = 0;
        smp();
        chk("t5i_gnt_after", 32'(grant_o), 0);

        // asynchronous reset mid data transfer
        nxt(); dm_stb_i = 1; dm_adr_i = 32'h400;
        nxt(); smp();
        chk("t6_gnt_pre", 32'(grant_o), 2);
        chk("t6_stb_pre", 32'(bus_stb_o), 1);
        #2; bus_ack_i = 1; rst_i = 0;
        #1;
        chk("t6_stb_rst", 32'(bus_stb_o), 0);
        chk("t6_gnt_rst", 32'(grant_o), 0);
        chk("t6_adr_rst", bus_adr_o, 0);
        chk("t6_ack_rst", 32'(dm_ack_o), 0);
        bus_ack_i = 0;
        smp(); rst_i = 1;
        chk("t6_starve_rst", 32'(dut.starve_cnt), 0);
        nxt(); smp();
        chk("t6_regrant", 32'(grant_o), 2);
        chk("t6_readr", bus_adr_o, 32'h400);
        nxt(); bus_ack_i = 1;
        nxt(); dm_stb_i = 0; bus_ack_i = 0;
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
